// File: rtl/fifo_reader_if.sv
// Signal bundle between fifo_reader, the SRAM FIFO pop port and the downstream stream.
// master is the reader's view; slave is the environment's view.
interface fifo_reader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  start_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  pop_valid_i;
  logic                  pop_grant_o;
  logic [DATA_WIDTH-1:0] pop_data_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  out_last_o;

  modport master (
    input  start_i, len_i, pop_valid_i, pop_data_i, out_ready_i,
    output busy_o, done_o, pop_grant_o, out_data_o, out_valid_o, out_last_o
  );

  modport slave (
    output start_i, len_i, pop_valid_i, pop_data_i, out_ready_i,
    input  busy_o, done_o, pop_grant_o, out_data_o, out_valid_o, out_last_o
  );
endinterface

// File: rtl/fifo_reader.sv
// Pops a fixed-length burst from the SRAM FIFO, absorbs its one-cycle read latency and
// re-times the words through a 3-entry buffer onto a valid/ready stream.
module fifo_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input logic           clk,
  input logic           rst,
  fifo_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [3];
  logic [2:0]            buf_last_q;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic pop_grant, pop_fire, out_valid, out_fire, capture;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign capture   = inflight_q;
  assign out_valid = (count_q != 2'd0);
  assign out_fire  = out_valid && bus.out_ready_i;
  // Reserve a buffer slot for the word still in flight from the SRAM.
  assign pop_grant = (state_q == StRun) && (remaining_q != '0) &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign pop_fire  = pop_grant && bus.pop_valid_i;

  always_comb begin
    count_d = count_q;
    if (capture && !out_fire) begin
      count_d = count_q + 2'd1;
    end else if (!capture && out_fire) begin
      count_d = count_q - 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            state_d     = StRun;
            remaining_d = bus.len_i;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (pop_fire) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Look at the post-fire occupancy so done follows the last word's fire directly.
        if ((count_d == 2'd0) && !inflight_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 2'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inflight_q  <= pop_fire;
      count_q     <= count_d;
      if (pop_fire) begin
        inflight_last_q <= (remaining_q == LEN_WIDTH'(1));
      end
      if (capture) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (out_fire) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Storage needs no reset: reads are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      buf_data_q[wr_ptr_q] <= bus.pop_data_i;
      buf_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign bus.pop_grant_o = pop_grant;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_valid ? buf_data_q[rd_ptr_q] : '0;
  assign bus.out_last_o  = out_valid && buf_last_q[rd_ptr_q];
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = (state_q == StDone);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(capture && !out_fire && (count_q == 2'd3)));

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized scoreboard bench for fifo_reader: a queue-based FIFO model feeds the DUT and
// a negedge monitor compares the stream and control outputs against a transfer-level model.
module tb_fifo_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_reader_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) intf ();

  fifo_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;

  logic [31:0] fifo_q[$];
  exp_t        exp_q[$];

  // Transfer-level model state
  int m_left = 0, m_held = 0, m_infl = 0;
  bit m_busy = 0, m_done_now = 0, m_done_next = 0;
  bit pop_fire_s = 0;
  int pops_xfer = 0;
  int t_start = 0, t_first = 0, t_lastout = 0;
  bit seen_first = 0;

  int pv_mode = 0, rdy_mode = 0, pat = 0;
  int sz0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pick(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return (pat % 3) == 0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a pop fire hands out the head word one cycle later
  always @(posedge clk) begin
    if (pop_fire_s && (fifo_q.size() != 0)) intf.pop_data_i <= fifo_q.pop_front();
  end

  always @(posedge clk) begin
    #1;
    pat++;
    intf.pop_valid_i = (fifo_q.size() != 0) && pick(pv_mode);
    intf.out_ready_i = pick(rdy_mode);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit   pf, of, was_busy;
    exp_t e;
    int   len;
    pf = intf.pop_valid_i && intf.pop_grant_o;
    of = intf.out_valid_o && intf.out_ready_i;
    pop_fire_s = pf;
    if (rst) begin
      m_left = 0; m_held = 0; m_infl = 0;
      m_busy = 0; m_done_now = 0; m_done_next = 0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      chk("busy", 32'(intf.busy_o), 32'(m_busy));
      chk("done", 32'(intf.done_o), 32'(m_done_now));
      chk("grant", 32'(intf.pop_grant_o), 32'(m_busy && (m_left > 0) && (m_held < 3)));
      chk("out_valid", 32'(intf.out_valid_o), 32'((m_held - m_infl) > 0));
      if (intf.out_valid_o && !seen_first) begin
        seen_first = 1;
        t_first    = int'(cyc);
      end
      if (of) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", intf.out_data_o, 32'hDEADBEEF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", intf.out_data_o, e.data);
          chk("out_last", 32'(intf.out_last_o), 32'(e.last));
          if (e.last) begin
            m_done_next = 1;
            t_lastout   = int'(cyc);
          end
        end
        m_held--;
      end
      if (pf) begin
        m_left--;
        m_held++;
        pops_xfer++;
      end
      m_infl = pf ? 1 : 0;
      if (m_done_now) begin
        m_busy     = 0;
        m_done_now = 0;
      end
      if (m_done_next) begin
        m_done_now  = 1;
        m_done_next = 0;
      end
      if (intf.start_i && !was_busy) begin
        len        = int'(intf.len_i);
        m_busy     = 1;
        m_left     = len;
        pops_xfer  = 0;
        seen_first = 0;
        t_start    = int'(cyc);
        if (len == 0) m_done_now = 1;
        for (int i = 0; i < len; i++) exp_q.push_back('{data: fifo_q[i], last: (i == len - 1)});
      end
    end
  end

  task automatic start_xfer(input int len);
    @(posedge clk); #1;
    intf.start_i = 1'b1;
    intf.len_i   = 8'(len);
    @(posedge clk); #1;
    intf.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!intf.done_o && (n < budget));
    chk("done_seen", 32'(intf.done_o), 32'd1);
  endtask

  task automatic run_xfer(input int len, input int extra, input int budget);
    for (int i = 0; i < len + extra; i++) fifo_q.push_back($urandom);
    sz0 = fifo_q.size();
    start_xfer(len);
    wait_done(budget);
    chk("pops_exact", 32'(fifo_q.size()), 32'(sz0 - len));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    intf.start_i = 1'b0;
    intf.len_i   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(intf.busy_o), 32'd0);
    chk("rst_done", 32'(intf.done_o), 32'd0);
    chk("rst_grant", 32'(intf.pop_grant_o), 32'd0);
    chk("rst_valid", 32'(intf.out_valid_o), 32'd0);
    chk("rst_data", intf.out_data_o, 32'd0);
    chk("rst_last", 32'(intf.out_last_o), 32'd0);

    // Basic 4-word transfer, full throughput
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
    pv_mode = 1; rdy_mode = 1;
    start_xfer(4);
    wait_done(50);
    chk("first_valid_latency", 32'(t_first - t_start), 32'd3);
    chk("back_to_back", 32'(t_lastout - t_first), 32'd3);
    chk("t1_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // Downstream stall: only three pops may be outstanding
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    sz0 = fifo_q.size();
    rdy_mode = 0;
    start_xfer(6);
    repeat (10) @(negedge clk);
    chk("stall_pops", 32'(pops_xfer), 32'd3);
    chk("stall_grant", 32'(intf.pop_grant_o), 32'd0);
    rdy_mode = 1;
    wait_done(60);
    chk("stall_pops_exact", 32'(fifo_q.size()), 32'(sz0 - 6));
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Sparse FIFO availability
    pv_mode = 3;
    run_xfer(5, 1, 80);

    // Zero-length command
    pv_mode = 1;
    run_xfer(0, 2, 5);
    chk("zero_no_pops", 32'(pops_xfer), 32'd0);

    // Reset two cycles into an 8-word transfer
    for (int i = 0; i < 10; i++) fifo_q.push_back($urandom);
    start_xfer(8);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(intf.out_valid_o), 32'd0);
    chk("mid_rst_data", intf.out_data_o, 32'd0);
    chk("mid_rst_busy", 32'(intf.busy_o), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(intf.out_valid_o), 32'd0);
    end
    run_xfer(2, 0, 30);

    // A start strobe during RUN must be ignored
    fifo_q.delete();
    pv_mode = 2; rdy_mode = 2;
    for (int i = 0; i < 10; i++) fifo_q.push_back($urandom);
    sz0 = fifo_q.size();
    start_xfer(7);
    repeat (2) @(posedge clk);
    #1;
    intf.start_i = 1'b1;
    intf.len_i   = 8'd3;
    @(posedge clk); #1;
    intf.start_i = 1'b0;
    wait_done(300);
    chk("ignored_start_pops", 32'(fifo_q.size()), 32'(sz0 - 7));
    chk("ignored_start_drained", 32'(exp_q.size()), 32'd0);

    // Random lengths under random handshakes
    for (int k = 0; k < 6; k++) begin
      int len;
      len = int'($urandom_range(1, 20));
      run_xfer(len, int'($urandom_range(0, 2)), len * 20 + 50);
    end

    // Maximum length at full throughput
    fifo_q.delete();
    pv_mode = 1; rdy_mode = 1;
    run_xfer(255, 0, 400);
    chk("max_len_throughput", 32'(t_lastout - t_first), 32'd254);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Pop-side consumer for the team's SRAM-backed FIFO. On a `start_i` command it pops exactly `len_i` words through the FIFO's pop handshake and absorbs the one-cycle SRAM read latency. Words are re-timed through a 3-entry output buffer onto a valid/ready stream, with `out_last_o` marking the final word. `done_o` pulses once the whole transfer has been delivered downstream.

## Interface
- `DATA_WIDTH`, 32, word width; equals the FIFO's data width.
- `LEN_WIDTH`, 8, width of the transfer length field.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  command strobe; accepted only in IDLE.
- `len_i`  in  LEN_WIDTH  words to transfer; sampled with `start_i`.
- `busy_o`  out  1  high in RUN, DRAIN and DONE.
- `done_o`  out  1  one-cycle pulse at end of transfer.
- `pop_valid_i`  in  1  FIFO non-empty.
- `pop_grant_o`  out  1  reader requests a pop.
- `pop_data_i`  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop fire.
- `out_data_o`  out  DATA_WIDTH  head of the output buffer.
- `out_valid_o`  out  1  output buffer non-empty.
- `out_ready_i`  in  1  downstream accepts.
- `out_last_o`  out  1  head word is the final word of the transfer.

## Operation
- **Handshakes**
  - Pop fire = `pop_valid_i && pop_grant_o`.
  - Output fire = `out_valid_o && out_ready_i`.
- **Internal state**
  - `remaining`: LEN_WIDTH pops still to issue.
  - `inflight`: 1 bit, a pop fired last cycle.
  - `inflight_last`: 1 bit, tag for the in-flight word.
  - Output buffer: 3 entries of {data, last}, circular, 2-bit wr/rd pointers, 0..3 occupancy count.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start_i` with `len_i != 0`; `remaining <= len_i`.
  - IDLE → DONE on `start_i` with `len_i == 0`; no pops are issued.
  - RUN → DRAIN on the pop fire that takes `remaining` from 1 to 0.
  - DRAIN → DONE when `count == 0` and `inflight == 0`.
  - DONE → IDLE unconditionally after one cycle.
  - `start_i` outside IDLE is ignored.
- **Pop grant:** `pop_grant_o = (state == RUN) && (remaining != 0) && (count + inflight < 3)`.
  - Registered-state function only; no combinational path from `out_ready_i` or `pop_valid_i`.
  - Depends on `pop_valid_i` only through the fire term.
- **Pop fire:** `remaining` decrements; `inflight <= 1`; `inflight_last <= (remaining == 1)`.
- **Capture:** when `inflight == 1`, `pop_data_i` and `inflight_last` are written at wr_ptr this cycle.
- **Buffer:**
  - Simultaneous capture and output fire: count unchanged, both pointers advance.
  - Pointers wrap 2→0.
  - The grant rule guarantees the buffer never overflows; this is an assertion target.
- **Outputs:**
  - `out_data_o` and `out_last_o` are the entry at rd_ptr.
  - `out_valid_o = (count != 0)`.
  - Held stable while `out_valid_o && !out_ready_i`.
- `done_o = (state == DONE)`; `busy_o = (state != IDLE)`.

## Timing
- **Reset:**
  - State IDLE; `remaining`, `inflight`, `count` and pointers are 0.
  - All outputs 0; `out_data_o` reads 0.
  - Reset mid-transfer drops buffered and in-flight words; FIFO read data arriving the cycle after reset is ignored.
- **Start:** `start_i` in cycle t → RUN in t+1; first `pop_grant_o` in t+1.
- **Latency:** pop fire in cycle p → word captured at the end of p+1 → `out_valid_o` high in p+2.
  - Minimum `start_i`-to-first-`out_valid_o`: 3 cycles.
- **Throughput:** with `pop_valid_i` and `out_ready_i` held high, one pop and one output word every cycle in steady state.
- **Downstream stall:** stalled `out_ready_i` fills the buffer; `pop_grant_o` drops when `count + inflight == 3`.
  - It rises the cycle after a free slot appears.
- **Empty FIFO:** `pop_valid_i` low stalls pops; `remaining` is held and the FSM stays in RUN indefinitely.
- **Completion:** `done_o` rises the cycle after the output fire of the `out_last_o` word (DRAIN → DONE).
  - Next `start_i` accepted from the cycle after `done_o`.
- **len_i == 0:** `done_o` high in t+1; no pops; `out_valid_o` stays 0.
- **len_i == 2^LEN_WIDTH−1:** all 255 words transfer; `remaining` never underflows.

## Test plan
- Reset, then `start_i` with `len_i = 4`, FIFO holding 0xA0..0xA3, `out_ready_i = 1` → words A0..A3 on consecutive cycles starting 3 cycles after start; `out_last_o` only with A3; `done_o` one cycle after A3's output fire.
- `len_i = 6`, `out_ready_i = 0` for 10 cycles, then 1 → exactly 3 pops issued, `pop_grant_o` low while stalled, no data loss, order preserved, 6 words total.
- `len_i = 5` with `pop_valid_i` toggling 1,0,0,1,… → pops occur only on fire cycles; `remaining` holds while stalled; 5 words delivered in order.
- `len_i = 0` → `done_o` pulse in t+1, zero pop grants, `busy_o` high for exactly 1 cycle.
- `rst` asserted two cycles into an 8-word transfer → all outputs 0 next cycle, `out_valid_o` stays 0 afterwards; a new `start_i` with `len_i = 2` then completes correctly.
- `start_i` pulsed during RUN with a different `len_i` → ignored; the original transfer length is delivered.
